// File: rtl/wb_b3_pkg.sv
// Shared Wishbone B3 burst constants and the burst address stepping rule.
package wb_b3_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // Widest byte address the helper handles; callers zero-extend and truncate.
  localparam int ADR_MAX_W = 64;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  // Next byte address of a burst: linear steps the whole word index, wrapping
  // bursts step only the low word bits and stay inside their aligned block.
  function automatic logic [ADR_MAX_W-1:0] next_burst_adr(input logic [ADR_MAX_W-1:0] adr,
                                                          input logic [1:0]           bte);
    logic [ADR_MAX_W-1:0] nxt;
    nxt = adr;
    case (bte)
      BTE_WRAP4:  nxt[3:2] = adr[3:2] + 2'd1;
      BTE_WRAP8:  nxt[4:2] = adr[4:2] + 3'd1;
      BTE_WRAP16: nxt[5:2] = adr[5:2] + 4'd1;
      BTE_LINEAR: nxt      = adr + ADR_MAX_W'(4);
      default:    nxt      = adr + ADR_MAX_W'(4);
    endcase
    nxt[1:0] = 2'b00;
    return nxt;
  endfunction

endpackage

// File: rtl/wb_burst_adr_gen.sv
// Burst address register: loads the word-aligned start address, steps on ack.
module wb_burst_adr_gen
  import wb_b3_pkg::*;
#(
  parameter int aw = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_i,
  input  logic [aw-1:0] load_adr_i,
  input  logic          adv_i,
  input  logic          clr_i,
  input  logic [1:0]    bte_i,
  output logic [aw-1:0] adr_o
);

  logic [aw-1:0] adr_d, adr_q;

  // Clear has priority so the bus address returns to zero outside a cycle.
  always_comb begin
    adr_d = adr_q;
    if (clr_i)       adr_d = '0;
    else if (load_i) adr_d = load_adr_i & ~aw'(3);
    else if (adv_i)  adr_d = aw'(next_burst_adr(ADR_MAX_W'(adr_q), bte_i));
  end

  // Address register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) adr_q <= '0;
    else          adr_q <= adr_d;
  end

  assign adr_o = adr_q;

endmodule

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 registered-feedback burst initiator: one command -> one bus cycle.
module wb_b3_burst_master
  import wb_b3_pkg::*;
#(
  parameter int aw    = 32,
  parameter int dw    = 32,
  parameter int len_w = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [aw-1:0]   cmd_adr_i,
  input  logic [len_w-1:0] cmd_len_i,
  input  logic            cmd_we_i,
  input  logic [1:0]      cmd_bte_i,
  input  logic [dw-1:0]   wr_dat_i,
  input  logic            wr_valid_i,
  output logic            wr_ready_o,
  output logic [dw-1:0]   rd_dat_o,
  output logic            rd_valid_o,
  output logic            done_o,
  output logic            err_o,
  output logic [len_w-1:0] xfer_cnt_o,
  output logic [aw-1:0]   wb_adr_o,
  output logic [1:0]      wb_bte_o,
  output logic [2:0]      wb_cti_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [dw/8-1:0] wb_sel_o,
  output logic [dw-1:0]   wb_dat_o,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  localparam logic [len_w:0] INC1 = (len_w+1)'(1);

  state_e            state_d, state_q;
  logic [len_w-1:0]  len_d, len_q, cnt_d, cnt_q, ld_d, ld_q;
  logic              we_d, we_q, cyc_d, cyc_q, stb_d, stb_q;
  logic [1:0]        bte_d, bte_q;
  logic [2:0]        cti_d, cti_q;
  logic [dw/8-1:0]   sel_d, sel_q;
  logic [dw-1:0]     wdat_d, wdat_q, rdat_d, rdat_q;
  logic              rvld_d, rvld_q, done_d, done_q, err_d, err_q;
  logic              adr_load, adr_adv, adr_clr;
  logic              ack_ok, bus_term, wr_ready, wr_fire, last_beat, next_last;
  logic [len_w:0]    cnt_inc;

  // Error/retry wins over a simultaneous ack; neither counts without stb.
  assign ack_ok    = cyc_q & stb_q & wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign bus_term  = cyc_q & stb_q & (wb_err_i | wb_rty_i);
  assign cnt_inc   = {1'b0, cnt_q} + INC1;
  assign last_beat = (cnt_inc == {1'b0, len_q});
  assign next_last = ((cnt_inc + INC1) == {1'b0, len_q});
  // Holding register refills in the same cycle it drains on an ack.
  assign wr_ready  = (state_q == ST_RUN) & we_q & (~stb_q | ack_ok) & (ld_q < len_q);
  assign wr_fire   = wr_valid_i & wr_ready;

  // Next-state and registered-output logic for the IDLE/RUN controller.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ld_d     = ld_q;
    we_d     = we_q;
    bte_d    = bte_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    cti_d    = cti_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    rvld_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    adr_load = 1'b0;
    adr_adv  = 1'b0;
    adr_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          cnt_d = '0;
          ld_d  = '0;
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_RUN;
            len_d    = cmd_len_i;
            we_d     = cmd_we_i;
            bte_d    = cmd_bte_i;
            cyc_d    = 1'b1;
            stb_d    = ~cmd_we_i;
            cti_d    = (cmd_len_i == len_w'(1)) ? CTI_CLASSIC : CTI_INCR;
            adr_load = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (wr_fire) begin
          wdat_d = wr_dat_i;
          ld_d   = ld_q + len_w'(1);
        end
        if (bus_term || (ack_ok && last_beat)) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          cti_d   = CTI_CLASSIC;
          we_d    = 1'b0;
          bte_d   = BTE_LINEAR;
          adr_clr = 1'b1;
          err_d   = bus_term;
          done_d  = ~bus_term;
        end else if (we_q) begin
          stb_d = ack_ok ? wr_fire : (stb_q | wr_fire);
        end
        if (ack_ok) begin
          cnt_d = cnt_inc[len_w-1:0];
          if (!we_q) begin
            rvld_d = 1'b1;
            rdat_d = wb_dat_i;
          end
          if (!last_beat) begin
            adr_adv = 1'b1;
            cti_d   = next_last ? CTI_EOB : CTI_INCR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sel_d = {(dw/8){stb_d}};
  end

  // Controller and bus-output registers; reset drops the bus with no handshake.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      ld_q    <= '0;
      we_q    <= 1'b0;
      bte_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      cti_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      rvld_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      we_q    <= we_d;
      bte_q   <= bte_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      cti_q   <= cti_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      rvld_q  <= rvld_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  wb_burst_adr_gen #(.aw(aw)) u_adr_gen (
    .clk_i      (wb_clk_i),
    .rst_n_i    (wb_rst_n_i),
    .load_i     (adr_load),
    .load_adr_i (cmd_adr_i),
    .adv_i      (adr_adv),
    .clr_i      (adr_clr),
    .bte_i      (bte_q),
    .adr_o      (wb_adr_o)
  );

  // Holding off a new command during the done/err pulse guarantees an idle cyc gap.
  assign cmd_ready_o = (state_q == ST_IDLE) & ~done_q & ~err_q;
  assign wr_ready_o  = wr_ready;
  assign rd_dat_o    = rdat_q;
  assign rd_valid_o  = rvld_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign xfer_cnt_o  = cnt_q;
  assign wb_bte_o    = bte_q;
  assign wb_cti_o    = cti_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = wdat_q;

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Directed bench for wb_b3_burst_master with a zero-wait B3 slave model.
module tb_wb_b3_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [7:0]  cmd_len_i;
  logic [1:0]  cmd_bte_i;
  logic [31:0] wr_dat_i = '0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o, rd_valid_o, done_o, err_o;
  logic [31:0] rd_dat_o;
  logic [7:0]  xfer_cnt_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [1:0]  wb_bte_o;
  logic [2:0]  wb_cti_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i, wb_rty_i;
  logic [3:0]  wb_sel_o;

  always #5 clk = ~clk;

  wb_b3_burst_master dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_adr_i(cmd_adr_i),
    .cmd_len_i(cmd_len_i), .cmd_we_i(cmd_we_i), .cmd_bte_i(cmd_bte_i),
    .wr_dat_i(wr_dat_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o), .done_o(done_o), .err_o(err_o),
    .xfer_cnt_o(xfer_cnt_o), .wb_adr_o(wb_adr_o), .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i)
  );

  // Slave: read data is a pattern of the word index, writes land in wr_mem.
  logic [31:0] wr_mem [0:255];
  int          sl_beats = 0;
  logic        err_en = 1'b0;
  int          err_at = 0;
  assign wb_err_i = wb_cyc_o & wb_stb_o & err_en & (sl_beats == err_at);
  assign wb_ack_i = wb_cyc_o & wb_stb_o & ~wb_err_i;
  assign wb_rty_i = 1'b0;
  assign wb_dat_i = 32'hD000_0000 | {24'h0, wb_adr_o[9:2]};

  // Write stream source with an optional gap before word gap_at.
  logic [31:0] wr_data [0:3];
  int wr_n = 0, wr_idx = 0, gap_at = 0, gap_len = 0, gap_ctr = 0;
  int cyc_n = 0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (!wb_cyc_o) sl_beats <= 0;
    else if (wb_ack_i) sl_beats <= sl_beats + 1;
    if (wb_cyc_o & wb_stb_o & wb_we_o & wb_ack_i) wr_mem[wb_adr_o[9:2]] <= wb_dat_o;
    if (wr_n == 0) wr_idx <= 0;
    else if (wr_valid_i & wr_ready_o) wr_idx <= wr_idx + 1;
  end

  always @(negedge clk) begin
    if (wr_n == 0) begin
      wr_valid_i = 1'b0;
      gap_ctr    = 0;
    end else if (wr_idx == gap_at && gap_ctr < gap_len) begin
      wr_valid_i = 1'b0;
      gap_ctr    = gap_ctr + 1;
    end else if (wr_idx < wr_n) begin
      wr_valid_i = 1'b1;
      wr_dat_i   = wr_data[wr_idx];
    end else begin
      wr_valid_i = 1'b0;
    end
  end

  // Bus monitor, sampled mid-cycle.
  logic [31:0] log_adr [0:63];
  logic [2:0]  log_cti [0:63];
  logic [1:0]  log_bte [0:63];
  logic [3:0]  log_sel [0:63];
  int          log_cyc [0:63];
  logic [31:0] log_rd  [0:63];
  int n_ack = 0, n_rd = 0, n_done = 0, n_err = 0, n_gap = 0, n_cyc = 0;
  int done_cyc = 0, err_cyc = 0, err_beat_cyc = 0;
  logic err_cyc_low = 1'b0;
  logic [31:0] gap_adr = '0;
  logic [2:0]  gap_cti = '0;

  always @(negedge clk) begin
    if (wb_cyc_o) n_cyc = n_cyc + 1;
    if (wb_cyc_o & wb_stb_o & wb_ack_i && n_ack < 64) begin
      log_adr[n_ack] = wb_adr_o;
      log_cti[n_ack] = wb_cti_o;
      log_bte[n_ack] = wb_bte_o;
      log_sel[n_ack] = wb_sel_o;
      log_cyc[n_ack] = cyc_n;
      n_ack = n_ack + 1;
    end
    if (wb_cyc_o & wb_stb_o & wb_err_i) err_beat_cyc = cyc_n;
    if (wb_cyc_o & ~wb_stb_o) begin
      n_gap   = n_gap + 1;
      gap_adr = wb_adr_o;
      gap_cti = wb_cti_o;
    end
    if (rd_valid_o && n_rd < 64) begin
      log_rd[n_rd] = rd_dat_o;
      n_rd = n_rd + 1;
    end
    if (done_o) begin
      n_done   = n_done + 1;
      done_cyc = cyc_n;
    end
    if (err_o) begin
      n_err       = n_err + 1;
      err_cyc     = cyc_n;
      err_cyc_low = ~wb_cyc_o;
    end
  end

  int n_cmp = 0, n_bad = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input int i, input logic [31:0] adr, input logic [2:0] cti,
                            input logic [1:0] bte);
    check($sformatf("adr[%0d]", i), log_adr[i], adr);
    check($sformatf("cti[%0d]", i), {29'h0, log_cti[i]}, {29'h0, cti});
    check($sformatf("bte[%0d]", i), {30'h0, log_bte[i]}, {30'h0, bte});
  endtask

  task automatic issue(input logic [31:0] a, input logic [7:0] l, input logic we,
                       input logic [1:0] bte);
    int k;
    @(negedge clk);
    cmd_adr_i = a; cmd_len_i = l; cmd_we_i = we; cmd_bte_i = bte; cmd_valid_i = 1'b1;
    k = 0;
    while (!cmd_ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_accepted", {31'h0, cmd_ready_o}, 32'h1);
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    acc_cyc = cyc_n;
  endtask

  task automatic wait_end(input int budget);
    int k, d0, e0;
    d0 = n_done; e0 = n_err; k = 0;
    while (n_done == d0 && n_err == e0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("end_seen", {31'h0, (n_done != d0) || (n_err != e0)}, 32'h1);
    repeat (2) @(posedge clk);
  endtask

  int a0, r0, d0, e0, c0, g0;

  initial begin
    cmd_valid_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0; cmd_we_i = 1'b0; cmd_bte_i = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'h0, cmd_ready_o}, 32'h1);
    check("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("rst_stb", {31'h0, wb_stb_o}, 32'h0);
    check("rst_done", {31'h0, done_o}, 32'h0);
    check("rst_xfer", {24'h0, xfer_cnt_o}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Linear read, len 4 at 0x100.
    a0 = n_ack; r0 = n_rd; d0 = n_done;
    issue(32'h100, 8'd4, 1'b0, 2'b00);
    wait_end(40);
    check("lin_acks", n_ack - a0, 4);
    check_beat(a0 + 0, 32'h100, 3'b010, 2'b00);
    check_beat(a0 + 1, 32'h104, 3'b010, 2'b00);
    check_beat(a0 + 2, 32'h108, 3'b010, 2'b00);
    check_beat(a0 + 3, 32'h10C, 3'b111, 2'b00);
    check("lin_sel", {28'h0, log_sel[a0]}, 32'hF);
    check("lin_first_stb", log_cyc[a0], acc_cyc);
    check("lin_rd_n", n_rd - r0, 4);
    check("lin_rd0", log_rd[r0 + 0], 32'hD000_0040);
    check("lin_rd3", log_rd[r0 + 3], 32'hD000_0043);
    check("lin_done_n", n_done - d0, 1);
    check("lin_done_lat", done_cyc - log_cyc[a0 + 3], 1);
    check("lin_xfer", {24'h0, xfer_cnt_o}, 32'd4);

    // Wrap4 read, len 4 at 0x108.
    a0 = n_ack; r0 = n_rd;
    issue(32'h108, 8'd4, 1'b0, 2'b01);
    wait_end(40);
    check("wr4_acks", n_ack - a0, 4);
    check_beat(a0 + 0, 32'h108, 3'b010, 2'b01);
    check_beat(a0 + 1, 32'h10C, 3'b010, 2'b01);
    check_beat(a0 + 2, 32'h100, 3'b010, 2'b01);
    check_beat(a0 + 3, 32'h104, 3'b111, 2'b01);
    check("wr4_rd0", log_rd[r0 + 0], 32'hD000_0042);
    check("wr4_rd1", log_rd[r0 + 1], 32'hD000_0043);
    check("wr4_rd2", log_rd[r0 + 2], 32'hD000_0040);
    check("wr4_rd3", log_rd[r0 + 3], 32'hD000_0041);

    // Write len 3 at 0x20 with a 2-cycle stream gap before beat 2; the first
    // stb-low cycle is the empty holding register right after accept.
    wr_data[0] = 32'hA1; wr_data[1] = 32'hB2; wr_data[2] = 32'hC3; wr_data[3] = 32'h0;
    gap_at = 1; gap_len = 2; wr_n = 3;
    a0 = n_ack; d0 = n_done; g0 = n_gap;
    issue(32'h20, 8'd3, 1'b1, 2'b00);
    wait_end(60);
    wr_n = 0;
    check("wr_acks", n_ack - a0, 3);
    check_beat(a0 + 0, 32'h20, 3'b010, 2'b00);
    check_beat(a0 + 1, 32'h24, 3'b010, 2'b00);
    check_beat(a0 + 2, 32'h28, 3'b111, 2'b00);
    check("wr_gap_cycles", n_gap - g0, 3);
    check("wr_gap_adr", gap_adr, 32'h24);
    check("wr_gap_cti", {29'h0, gap_cti}, 32'h2);
    check("wr_mem0", wr_mem[8], 32'hA1);
    check("wr_mem1", wr_mem[9], 32'hB2);
    check("wr_mem2", wr_mem[10], 32'hC3);
    check("wr_done_n", n_done - d0, 1);
    check("wr_xfer", {24'h0, xfer_cnt_o}, 32'd3);

    // Single-beat read at 0x40.
    a0 = n_ack; r0 = n_rd; c0 = n_cyc;
    issue(32'h40, 8'd1, 1'b0, 2'b00);
    wait_end(20);
    check("one_acks", n_ack - a0, 1);
    check_beat(a0, 32'h40, 3'b000, 2'b00);
    check("one_cyc_len", n_cyc - c0, 1);
    check("one_rd", log_rd[r0], 32'hD000_0010);

    // Zero-length command.
    c0 = n_cyc; d0 = n_done;
    issue(32'h80, 8'd0, 1'b0, 2'b00);
    wait_end(10);
    check("len0_done_n", n_done - d0, 1);
    check("len0_done_lat", done_cyc, acc_cyc);
    check("len0_no_cyc", n_cyc - c0, 0);

    // Read len 8 with an error on beat 3.
    err_en = 1'b1; err_at = 2;
    a0 = n_ack; r0 = n_rd; d0 = n_done; e0 = n_err;
    issue(32'h200, 8'd8, 1'b0, 2'b00);
    wait_end(40);
    err_en = 1'b0;
    check("err_acks", n_ack - a0, 2);
    check("err_rd_n", n_rd - r0, 2);
    check("err_n", n_err - e0, 1);
    check("err_no_done", n_done - d0, 0);
    check("err_lat", err_cyc - err_beat_cyc, 1);
    check("err_cyc_low", {31'h0, err_cyc_low}, 32'h1);
    check("err_xfer", {24'h0, xfer_cnt_o}, 32'd2);

    // Asynchronous reset in the middle of a burst.
    issue(32'h0, 8'd8, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    #1 check("rst_busy", {31'h0, wb_cyc_o}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("mid_rst_stb", {31'h0, wb_stb_o}, 32'h0);
    check("mid_rst_ready", {31'h0, cmd_ready_o}, 32'h1);
    check("mid_rst_rdv", {31'h0, rd_valid_o}, 32'h0);
    check("mid_rst_xfer", {24'h0, xfer_cnt_o}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
